// File: rtl/scroll_display_ctrl_pkg.sv
// Shared definitions for the scrolling 7-seg controller.
//   ANODE_OFF   : all anodes dark (active-low), wide enough for any digit count
//   BLANK_CHAR  : char code driven while in reset
//   scroll_dir_e: meaning of the dir input
//   clog2       : index width helper, never returns less than 1
package scroll_display_ctrl_pkg;

    localparam logic [31:0] ANODE_OFF  = '1;
    localparam logic [31:0] BLANK_CHAR = '0;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } scroll_dir_e;

    function automatic int clog2(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/scroll_display_ctrl_scan.sv
// Digit scanner: slot timer, digit index, blanking window, anode decode and
// frame pulse.
//   clk_i, reset_i   : clock / async active-low reset
//   an_o             : active-low anodes, an_o[NUM_DIGITS-1] is the leftmost digit
//   frame_tick_o     : high for the first cycle of digit 0's slot after a wrap
//   slot_end_o       : current cycle is the last one of a slot
//   wrap_o           : current cycle is the last one of the frame
//   idx_next_o       : digit index that will be current next cycle
module scroll_display_ctrl_scan
    import scroll_display_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 5000,
    parameter int BLANK_CYC   = 16
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    output logic [NUM_DIGITS-1:0]            an_o,
    output logic                             frame_tick_o,
    output logic                             slot_end_o,
    output logic                             wrap_o,
    output logic [clog2(NUM_DIGITS)-1:0]     idx_next_o
);

    localparam int SLOT_W = clog2(REFRESH_DIV);
    localparam int IDX_W  = clog2(NUM_DIGITS);

    localparam logic [SLOT_W-1:0]     SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0]     SLOT_LIT   = SLOT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] LEFT_ONE   = NUM_DIGITS'(1) << (NUM_DIGITS - 1);

    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_tick_q;
    logic                  slot_end;
    logic                  wrap;

    assign slot_end = (slot_q == SLOT_LAST);
    assign wrap     = slot_end && (idx_q == IDX_LAST);

    // Anodes are decoded from the next counter values so the registered
    // pattern lines up exactly with slot_q/idx_q.
    always_comb begin
        slot_d = slot_end ? '0 : slot_q + 1'b1;
        idx_d  = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        an_d = ANODE_OFF[NUM_DIGITS-1:0];
        if (slot_d >= SLOT_LIT) begin
            an_d = ~(LEFT_ONE >> idx_d);
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            slot_q       <= '0;
            idx_q        <= '0;
            an_q         <= ANODE_OFF[NUM_DIGITS-1:0];
            frame_tick_q <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            frame_tick_q <= wrap;
        end
    end

    assign an_o         = an_q;
    assign frame_tick_o = frame_tick_q;
    assign slot_end_o   = slot_end;
    assign wrap_o       = wrap;
    assign idx_next_o   = idx_d;

endmodule

// File: rtl/scroll_display_ctrl.sv
// Scrolling-text controller for a multiplexed 7-seg bank.
//   clk_i, reset_i : clock / async active-low reset
//   mode_i         : 0 manual stepping via step_i, 1 auto scrolling every SCROLL_DIV cycles
//   dir_i          : 0 offset +1 per step, 1 offset -1 per step
//   pause_i        : freeze offset and reject steps; scanning continues
//   step_i         : debounced single-cycle step pulse (manual mode only)
//   wr_en_i/wr_addr_i/wr_data_i : message store write port
//   an_o           : active-low anodes, an_o[NUM_DIGITS-1] is the leftmost digit
//   char_o         : char code of the currently lit digit
//   offset_o       : message index shown on the leftmost digit
//   frame_tick_o   : one-cycle pulse at the start of each frame
module scroll_display_ctrl
    import scroll_display_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int MSG_LEN     = 16,
    parameter int CHAR_W      = 4,
    parameter int REFRESH_DIV = 5000,
    parameter int BLANK_CYC   = 16,
    parameter int SCROLL_DIV  = 2500000
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          mode_i,
    input  logic                          dir_i,
    input  logic                          pause_i,
    input  logic                          step_i,
    input  logic                          wr_en_i,
    input  logic [clog2(MSG_LEN)-1:0]     wr_addr_i,
    input  logic [CHAR_W-1:0]             wr_data_i,
    output logic [NUM_DIGITS-1:0]         an_o,
    output logic [CHAR_W-1:0]             char_o,
    output logic [clog2(MSG_LEN)-1:0]     offset_o,
    output logic                          frame_tick_o
);

    localparam int AW    = clog2(MSG_LEN);
    localparam int IDX_W = clog2(NUM_DIGITS);
    localparam int SCW   = clog2(SCROLL_DIV);

    localparam logic [AW-1:0]  OFF_LAST   = AW'(MSG_LEN - 1);
    localparam logic [AW:0]    MSG_LEN_W  = (AW + 1)'(MSG_LEN);
    localparam logic [SCW-1:0] SCROLL_END = SCW'(SCROLL_DIV - 1);

    logic [CHAR_W-1:0] msg_q [MSG_LEN];
    logic [SCW-1:0]    scroll_cnt_q, scroll_cnt_d;
    logic              pending_q, pending_d;
    logic [AW-1:0]     offset_q, offset_d;
    logic [CHAR_W-1:0] char_q, char_d;

    logic              slot_end;
    logic              wrap;
    logic [IDX_W-1:0]  idx_next;
    logic              scroll_hold;
    logic              auto_tick;
    logic              step_acc;
    logic              apply;
    logic              wr_ok;
    logic [AW:0]       rd_sum;
    logic [AW-1:0]     rd_addr;

    scroll_display_ctrl_scan #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYC   (BLANK_CYC)
    ) u_scan (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .an_o         (an_o),
        .frame_tick_o (frame_tick_o),
        .slot_end_o   (slot_end),
        .wrap_o       (wrap),
        .idx_next_o   (idx_next)
    );

    assign wr_ok = wr_en_i && (32'(wr_addr_i) < MSG_LEN);

    // The scroll timer idles at 0 whenever it is not the step source, so a
    // return to auto mode always starts a full interval.
    assign scroll_hold = !mode_i || pause_i;
    assign auto_tick   = !scroll_hold && (scroll_cnt_q == SCROLL_END);
    assign step_acc    = !pause_i && (mode_i ? auto_tick : step_i);

    // Offset moves only on the edge that opens a new frame, so a frame
    // never mixes two offsets.
    assign apply = wrap && pending_q && !pause_i;

    always_comb begin
        scroll_cnt_d = (scroll_hold || auto_tick) ? '0 : scroll_cnt_q + 1'b1;

        // A step landing on the update edge belongs to the following frame.
        pending_d = apply ? step_acc : (pending_q || step_acc);

        offset_d = offset_q;
        if (apply) begin
            if (scroll_dir_e'(dir_i) == DIR_DOWN) begin
                offset_d = (offset_q == '0) ? OFF_LAST : offset_q - 1'b1;
            end else begin
                offset_d = (offset_q == OFF_LAST) ? '0 : offset_q + 1'b1;
            end
        end

        // Char is latched at slot start using the offset and index that
        // take effect on that same edge.
        rd_sum  = {1'b0, offset_d} + (AW + 1)'(idx_next);
        rd_addr = (rd_sum >= MSG_LEN_W) ? AW'(rd_sum - MSG_LEN_W) : AW'(rd_sum);
        char_d  = slot_end ? msg_q[rd_addr] : char_q;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                msg_q[i] <= '0;
            end
            scroll_cnt_q <= '0;
            pending_q    <= 1'b0;
            offset_q     <= '0;
            char_q       <= BLANK_CHAR[CHAR_W-1:0];
        end else begin
            if (wr_ok) begin
                msg_q[wr_addr_i] <= wr_data_i;
            end
            scroll_cnt_q <= scroll_cnt_d;
            pending_q    <= pending_d;
            offset_q     <= offset_d;
            char_q       <= char_d;
        end
    end

    assign char_o   = char_q;
    assign offset_o = offset_q;

endmodule

// File: tb/tb_scroll_display_ctrl.sv
module tb_scroll_display_ctrl;

    localparam int ND = 4;
    localparam int ML = 16;
    localparam int CW = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int SD = 64;
    localparam int FRAME = ND * RD;

    typedef struct packed {
        logic [3:0]  off;
        logic [15:0] chars;
    } exp_t;

    logic          clk_i;
    logic          reset_i;
    logic          mode_i;
    logic          dir_i;
    logic          pause_i;
    logic          step_i;
    logic          wr_en_i;
    logic [3:0]    wr_addr_i;
    logic [CW-1:0] wr_data_i;
    logic [ND-1:0] an_o;
    logic [CW-1:0] char_o;
    logic [3:0]    offset_o;
    logic          frame_tick_o;

    int   n_tests;
    int   n_fail;
    exp_t sb_q[$];
    logic [3:0] msg_model [ML];

    scroll_display_ctrl #(
        .NUM_DIGITS  (ND),
        .MSG_LEN     (ML),
        .CHAR_W      (CW),
        .REFRESH_DIV (RD),
        .BLANK_CYC   (BC),
        .SCROLL_DIV  (SD)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .mode_i       (mode_i),
        .dir_i        (dir_i),
        .pause_i      (pause_i),
        .step_i       (step_i),
        .wr_en_i      (wr_en_i),
        .wr_addr_i    (wr_addr_i),
        .wr_data_i    (wr_data_i),
        .an_o         (an_o),
        .char_o       (char_o),
        .offset_o     (offset_o),
        .frame_tick_o (frame_tick_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_lit(input logic [3:0] off, input logic [3:0] c0, input logic [3:0] c1,
                            input logic [3:0] c2, input logic [3:0] c3);
        exp_t e;
        e.off   = off;
        e.chars = {c3, c2, c1, c0};
        sb_q.push_back(e);
    endtask

    task automatic push_model(input logic [3:0] off);
        push_lit(off, msg_model[off], msg_model[4'(off + 4'd1)],
                 msg_model[4'(off + 4'd2)], msg_model[4'(off + 4'd3)]);
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!frame_tick_o && n < FRAME + 8);
        if (!frame_tick_o) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_frame: got no frame_tick within %0d cycles expected one", n);
        end
    endtask

    task automatic pulse_step(input int delay);
        repeat (delay) @(negedge clk_i);
        step_i = 1'b1;
        @(negedge clk_i);
        step_i = 1'b0;
    endtask

    // Monitor: whenever a frame starts and an expectation is queued, check
    // every cycle of that frame against it.
    initial begin
        exp_t       rec;
        logic [3:0] exp_an;
        logic [3:0] exp_ch;
        int         d;
        int         s;
        forever begin
            @(posedge clk_i);
            #1;
            if (frame_tick_o && sb_q.size() > 0) begin
                rec = sb_q.pop_front();
                for (int k = 0; k < FRAME; k++) begin
                    if (k > 0) begin
                        @(posedge clk_i);
                        #1;
                    end
                    d      = k / RD;
                    s      = k % RD;
                    exp_an = (s < BC) ? 4'hF : ~(4'b1000 >> d);
                    exp_ch = rec.chars[d*4 +: 4];
                    chk($sformatf("an k=%0d", k), 32'(an_o), 32'(exp_an));
                    chk($sformatf("char k=%0d", k), 32'(char_o), 32'(exp_ch));
                    chk($sformatf("offset k=%0d", k), 32'(offset_o), 32'(rec.off));
                    chk($sformatf("frame_tick k=%0d", k), 32'(frame_tick_o), (k == 0) ? 32'd1 : 32'd0);
                end
            end
        end
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset_i   = 1'b1;
        mode_i    = 1'b0;
        dir_i     = 1'b0;
        pause_i   = 1'b0;
        step_i    = 1'b0;
        wr_en_i   = 1'b0;
        wr_addr_i = '0;
        wr_data_i = '0;
        for (int i = 0; i < ML; i++) msg_model[i] = '0;

        #3 reset_i = 1'b0;
        #1;
        chk("reset an", 32'(an_o), 32'hF);
        chk("reset char", 32'(char_o), 32'h0);
        chk("reset offset", 32'(offset_o), 32'h0);
        chk("reset frame_tick", 32'(frame_tick_o), 32'h0);
        repeat (3) @(negedge clk_i);
        reset_i = 1'b1;

        // Load msg[i] = i
        for (int i = 0; i < ML; i++) begin
            @(negedge clk_i);
            wr_en_i   = 1'b1;
            wr_addr_i = 4'(i);
            wr_data_i = 4'(i);
            msg_model[i] = 4'(i);
        end
        @(negedge clk_i);
        wr_en_i = 1'b0;

        // Static frames: chars 0,1,2,3
        wait_frame();
        push_lit(4'd0, 4'd0, 4'd1, 4'd2, 4'd3);

        // Three steps in one frame collapse to one advance
        wait_frame();
        push_lit(4'd1, 4'd1, 4'd2, 4'd3, 4'd4);
        pulse_step(2);
        pulse_step(2);
        pulse_step(3);

        // One step per frame up to offset 15
        for (int i = 2; i <= 15; i++) begin
            wait_frame();
            pulse_step(2);
            if (i == 15) push_lit(4'd15, 4'hF, 4'h0, 4'h1, 4'h2);
            else         push_model(4'(i));
        end

        // 15 + 1 wraps to 0
        wait_frame();
        pulse_step(2);
        push_lit(4'd0, 4'd0, 4'd1, 4'd2, 4'd3);

        // Reverse: 0 - 1 wraps to 15
        wait_frame();
        dir_i = 1'b1;
        pulse_step(2);
        push_lit(4'd15, 4'hF, 4'h0, 4'h1, 4'h2);

        // Step on the frame_tick cycle counts toward the next frame
        wait_frame();
        dir_i  = 1'b0;
        step_i = 1'b1;
        @(negedge clk_i);
        step_i = 1'b0;
        push_lit(4'd0, 4'd0, 4'd1, 4'd2, 4'd3);

        // Auto mode: tick lands in the third frame, applied at the fourth
        wait_frame();
        push_model(4'd0);
        repeat (4) @(negedge clk_i);
        mode_i = 1'b1;
        wait_frame();
        push_model(4'd0);
        pulse_step(5);
        wait_frame();
        push_model(4'd1);
        wait_frame();
        push_model(4'd1);
        wait_frame();
        push_model(4'd2);

        // Pause for over 200 cycles: offset frozen, steps ignored
        wait_frame();
        push_model(4'd2);
        pause_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_frame();
            push_model(4'd2);
            pulse_step(5);
        end
        wait_frame();
        push_model(4'd2);
        repeat (8) @(negedge clk_i);
        pause_i = 1'b0;
        wait_frame();
        push_model(4'd2);
        wait_frame();
        push_model(4'd3);
        wait_frame();
        push_model(4'd3);
        mode_i = 1'b0;

        // Pending step survives a pause and is applied after release
        wait_frame();
        push_model(4'd3);
        pulse_step(2);
        repeat (2) @(negedge clk_i);
        pause_i = 1'b1;
        wait_frame();
        push_model(4'd4);
        repeat (4) @(negedge clk_i);
        pause_i = 1'b0;

        // Write to the lit entry mid-slot (digit 1 shows msg[5])
        wait_frame();
        repeat (12) @(negedge clk_i);
        wr_en_i   = 1'b1;
        wr_addr_i = 4'd5;
        wr_data_i = 4'hA;
        @(negedge clk_i);
        wr_en_i = 1'b0;
        msg_model[5] = 4'hA;
        push_lit(4'd4, 4'h4, 4'hA, 4'h6, 4'h7);

        // Async reset mid-frame with a pending step
        wait_frame();
        wait_frame();
        pulse_step(2);
        repeat (8) @(negedge clk_i);
        #2 reset_i = 1'b0;
        #1;
        chk("midreset an", 32'(an_o), 32'hF);
        chk("midreset offset", 32'(offset_o), 32'h0);
        chk("midreset char", 32'(char_o), 32'h0);
        for (int i = 0; i < ML; i++) msg_model[i] = '0;
        repeat (3) @(negedge clk_i);
        reset_i = 1'b1;
        wait_frame();
        push_lit(4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        wait_frame();
        push_lit(4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        wait_frame();
        repeat (FRAME + 8) @(negedge clk_i);
        chk("scoreboard drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
